// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, RV32 opcodes,
// datapath mux select codes and the decoded instruction class.
package multicycle_ctrl_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_EXEC_ALU = 4'd2;
    localparam logic [3:0] ST_EXEC_BR  = 4'd3;
    localparam logic [3:0] ST_EXEC_JMP = 4'd4;
    localparam logic [3:0] ST_MEM_ADDR = 4'd5;
    localparam logic [3:0] ST_MEM_RD   = 4'd6;
    localparam logic [3:0] ST_MEM_WR   = 4'd7;
    localparam logic [3:0] ST_WB_ALU   = 4'd8;
    localparam logic [3:0] ST_WB_MEM   = 4'd9;
    localparam logic [3:0] ST_HALT     = 4'd10;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] PCSRC_PC4  = 2'd0;
    localparam logic [1:0] PCSRC_ALU  = 2'd1;
    localparam logic [1:0] PCSRC_IMM  = 2'd2;

    localparam logic [1:0] ASRC_RS1   = 2'd0;
    localparam logic [1:0] ASRC_PC    = 2'd1;
    localparam logic [1:0] ASRC_ZERO  = 2'd2;

    localparam logic [1:0] BSRC_RS2   = 2'd0;
    localparam logic [1:0] BSRC_IMM   = 2'd1;
    localparam logic [1:0] BSRC_FOUR  = 2'd2;

    localparam logic [1:0] WBSEL_ALU  = 2'd0;
    localparam logic [1:0] WBSEL_MEM  = 2'd1;
    localparam logic [1:0] WBSEL_PC4  = 2'd2;

    typedef enum logic [3:0] {
        CL_LOAD, CL_STORE, CL_OP, CL_OPIMM, CL_LUI, CL_AUIPC,
        CL_BRANCH, CL_JAL, CL_JALR, CL_SYSTEM, CL_ILLEGAL
    } iclass_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Purely combinational opcode to instruction-class decoder.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output iclass_t    o_class
);

    always_comb begin
        o_class = CL_ILLEGAL;
        case (i_opcode)
            OPC_LOAD:   o_class = CL_LOAD;
            OPC_STORE:  o_class = CL_STORE;
            OPC_OP:     o_class = CL_OP;
            OPC_OPIMM:  o_class = CL_OPIMM;
            OPC_LUI:    o_class = CL_LUI;
            OPC_AUIPC:  o_class = CL_AUIPC;
            OPC_BRANCH: o_class = CL_BRANCH;
            OPC_JAL:    o_class = CL_JAL;
            OPC_JALR:   o_class = CL_JALR;
            OPC_SYSTEM: o_class = CL_SYSTEM;
            default:    o_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects and one-cycle write enables.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [31:0] iInstr,
    input  logic        iBrTaken,
    input  logic        iMemReady,
    output logic        oMemReq,
    output logic        oMemWrite,
    output logic        oIorD,
    output logic        oIRWrite,
    output logic        oPCWrite,
    output logic [1:0]  oPCSrc,
    output logic [1:0]  oALUSrcA,
    output logic [1:0]  oALUSrcB,
    output logic        oRegWrite,
    output logic [1:0]  oWBSel,
    output logic        oIllegal,
    output logic [3:0]  oState
);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       r_illegal;
    iclass_t    w_class;
    logic       w_unused_instr;

    // Only the major opcode steers sequencing; the rest belongs to the datapath.
    assign w_unused_instr = ^iInstr[31:7];

    ctrl_decode u_decode (
        .i_opcode (iInstr[6:0]),
        .o_class  (w_class)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state   <= ST_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE && w_class == CL_ILLEGAL)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:    if (iMemReady) w_next = ST_DECODE;
            ST_DECODE: begin
                case (w_class)
                    CL_LOAD, CL_STORE:                   w_next = ST_MEM_ADDR;
                    CL_OP, CL_OPIMM, CL_LUI, CL_AUIPC:   w_next = ST_EXEC_ALU;
                    CL_BRANCH:                           w_next = ST_EXEC_BR;
                    CL_JAL, CL_JALR:                     w_next = ST_EXEC_JMP;
                    CL_SYSTEM:                           w_next = ST_FETCH;
                    default: w_next = (HALT_ON_ILLEGAL != 0) ? ST_HALT : ST_FETCH;
                endcase
            end
            ST_EXEC_ALU: w_next = ST_WB_ALU;
            ST_EXEC_BR:  w_next = ST_FETCH;
            ST_EXEC_JMP: w_next = ST_FETCH;
            ST_MEM_ADDR: w_next = (w_class == CL_STORE) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (iMemReady) w_next = ST_WB_MEM;
            ST_MEM_WR:   if (iMemReady) w_next = ST_FETCH;
            ST_WB_ALU:   w_next = ST_FETCH;
            ST_WB_MEM:   w_next = ST_FETCH;
            ST_HALT:     w_next = ST_HALT;
            default:     w_next = ST_FETCH;
        endcase
    end

    // Everything is forced quiet while reset is held, including the FETCH request.
    always_comb begin
        oMemReq   = 1'b0;
        oMemWrite = 1'b0;
        oIorD     = 1'b0;
        oIRWrite  = 1'b0;
        oPCWrite  = 1'b0;
        oPCSrc    = PCSRC_PC4;
        oALUSrcA  = ASRC_RS1;
        oALUSrcB  = BSRC_RS2;
        oRegWrite = 1'b0;
        oWBSel    = WBSEL_ALU;
        if (!iRST) begin
            case (r_state)
                ST_FETCH: begin
                    oMemReq  = 1'b1;
                    oIRWrite = iMemReady;
                    oPCWrite = iMemReady;
                end
                ST_EXEC_ALU: begin
                    case (w_class)
                        CL_OPIMM: oALUSrcB = BSRC_IMM;
                        CL_LUI: begin
                            oALUSrcA = ASRC_ZERO;
                            oALUSrcB = BSRC_IMM;
                        end
                        CL_AUIPC: begin
                            oALUSrcA = ASRC_PC;
                            oALUSrcB = BSRC_IMM;
                        end
                        default: ;
                    endcase
                end
                ST_EXEC_BR: begin
                    oPCWrite = iBrTaken;
                    oPCSrc   = PCSRC_IMM;
                end
                ST_EXEC_JMP: begin
                    oRegWrite = 1'b1;
                    oWBSel    = WBSEL_PC4;
                    oPCWrite  = 1'b1;
                    if (w_class == CL_JALR) begin
                        oPCSrc   = PCSRC_ALU;
                        oALUSrcB = BSRC_IMM;
                    end else begin
                        oPCSrc   = PCSRC_IMM;
                    end
                end
                ST_MEM_ADDR: oALUSrcB = BSRC_IMM;
                ST_MEM_RD: begin
                    oMemReq = 1'b1;
                    oIorD   = 1'b1;
                end
                ST_MEM_WR: begin
                    oMemReq   = 1'b1;
                    oIorD     = 1'b1;
                    oMemWrite = 1'b1;
                end
                ST_WB_ALU: oRegWrite = 1'b1;
                ST_WB_MEM: begin
                    oRegWrite = 1'b1;
                    oWBSel    = WBSEL_MEM;
                end
                default: ;
            endcase
        end
    end

    assign oIllegal = r_illegal;
    assign oState   = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl (halting and non-halting builds).
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        br;
    logic        rdy;

    logic       a_req, a_mw, a_iord, a_irw, a_pcw, a_rw, a_ill;
    logic [1:0] a_pcsrc, a_srca, a_srcb, a_wbsel;
    logic [3:0] a_state;
    logic       b_req, b_mw, b_iord, b_irw, b_pcw, b_rw, b_ill;
    logic [1:0] b_pcsrc, b_srca, b_srcb, b_wbsel;
    logic [3:0] b_state;

    int n_chk = 0;
    int n_bad = 0;

    multicycle_ctrl #(.HALT_ON_ILLEGAL(1)) u_dut_halt (
        .iCLK(clk), .iRST(rst), .iInstr(instr), .iBrTaken(br), .iMemReady(rdy),
        .oMemReq(a_req), .oMemWrite(a_mw), .oIorD(a_iord), .oIRWrite(a_irw),
        .oPCWrite(a_pcw), .oPCSrc(a_pcsrc), .oALUSrcA(a_srca), .oALUSrcB(a_srcb),
        .oRegWrite(a_rw), .oWBSel(a_wbsel), .oIllegal(a_ill), .oState(a_state)
    );

    multicycle_ctrl #(.HALT_ON_ILLEGAL(0)) u_dut_nop (
        .iCLK(clk), .iRST(rst), .iInstr(instr), .iBrTaken(br), .iMemReady(rdy),
        .oMemReq(b_req), .oMemWrite(b_mw), .oIorD(b_iord), .oIRWrite(b_irw),
        .oPCWrite(b_pcw), .oPCSrc(b_pcsrc), .oALUSrcA(b_srca), .oALUSrcB(b_srcb),
        .oRegWrite(b_rw), .oWBSel(b_wbsel), .oIllegal(b_ill), .oState(b_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // FETCH (zero-wait) and DECODE; returns one unit after the edge into the exec state.
    task automatic run_fd(input logic [31:0] ins, input string nm);
        instr = ins;
        rdy   = 1'b1;
        #1;
        chk({nm, " fetch state"}, a_state, ST_FETCH);
        chk({nm, " fetch req"}, {a_req, a_iord, a_mw}, 3'b100);
        chk({nm, " fetch irw/pcw"}, {a_irw, a_pcw, a_pcsrc}, 4'b1100);
        step;
        #1;
        chk({nm, " decode state"}, a_state, ST_DECODE);
        chk({nm, " decode enables"}, {a_pcw, a_rw, a_irw, a_mw, a_req}, 5'b0);
        step;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        rdy = 1'b1;
        br  = 1'b0;
        step;
        step;
        #1;
        chk("rst state", a_state, ST_FETCH);
        chk("rst quiet", {a_req, a_pcw, a_rw, a_irw, a_mw, a_ill}, 6'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        instr = 32'h0;
        br    = 1'b0;
        rdy   = 1'b0;
        step;
        step;
        #1;
        chk("reset state", a_state, ST_FETCH);
        chk("reset quiet", {a_req, a_pcw, a_rw, a_irw, a_mw, a_ill}, 6'b0);
        rst = 1'b0;
        #1;
        chk("first req", {a_req, a_iord, a_mw}, 3'b100);
        chk("stall no irw", {a_irw, a_pcw}, 2'b00);
        step;
        #1;
        chk("stall state", a_state, ST_FETCH);
        chk("stall req held", a_req, 1'b1);

        // ADDI x1,x0,5
        run_fd(32'h00500093, "addi");
        #1;
        chk("addi exec state", a_state, ST_EXEC_ALU);
        chk("addi exec sel", {a_srca, a_srcb, a_rw}, {ASRC_RS1, BSRC_IMM, 1'b0});
        step;
        #1;
        chk("addi wb state", a_state, ST_WB_ALU);
        chk("addi wb", {a_rw, a_wbsel, a_pcw}, {1'b1, WBSEL_ALU, 1'b0});
        step;

        // LW x2,0(x1) with three wait cycles in MEM_RD
        run_fd(32'h0000A103, "lw");
        #1;
        chk("lw maddr state", a_state, ST_MEM_ADDR);
        chk("lw maddr sel", {a_srca, a_srcb, a_req}, {ASRC_RS1, BSRC_IMM, 1'b0});
        step;
        for (int c = 0; c < 4; c++) begin
            rdy = (c == 3);
            #1;
            chk("lw memrd state", a_state, ST_MEM_RD);
            chk("lw memrd req", {a_req, a_iord, a_mw, a_rw}, 4'b1100);
            step;
        end
        rdy = 1'b1;
        #1;
        chk("lw wbmem state", a_state, ST_WB_MEM);
        chk("lw wbmem", {a_rw, a_wbsel, a_req}, {1'b1, WBSEL_MEM, 1'b0});
        step;

        // BEQ not taken, then taken
        run_fd(32'h00000463, "beq0");
        br = 1'b0;
        #1;
        chk("beq0 state", a_state, ST_EXEC_BR);
        chk("beq0 ctl", {a_pcw, a_pcsrc, a_srca, a_srcb}, {1'b0, PCSRC_IMM, ASRC_RS1, BSRC_RS2});
        step;
        run_fd(32'h00000463, "beq1");
        br = 1'b1;
        #1;
        chk("beq1 ctl", {a_pcw, a_pcsrc, a_rw}, {1'b1, PCSRC_IMM, 1'b0});
        step;
        br = 1'b0;

        // JALR x1,0(x1)
        run_fd(32'h000080E7, "jalr");
        #1;
        chk("jalr state", a_state, ST_EXEC_JMP);
        chk("jalr ctl", {a_rw, a_wbsel, a_pcsrc, a_pcw}, {1'b1, WBSEL_PC4, PCSRC_ALU, 1'b1});
        chk("jalr sel", {a_srca, a_srcb}, {ASRC_RS1, BSRC_IMM});
        step;

        // AUIPC x1,0
        run_fd(32'h00000097, "auipc");
        #1;
        chk("auipc sel", {a_srca, a_srcb}, {ASRC_PC, BSRC_IMM});
        step;
        #1;
        chk("auipc wb state", a_state, ST_WB_ALU);
        step;

        // ECALL returns straight to FETCH
        run_fd(32'h00000073, "system");
        #1;
        chk("system refetch", a_state, ST_FETCH);

        // Illegal opcode: halting build parks, non-halting build refetches
        do_reset();
        run_fd(32'h0000007F, "illegal");
        #1;
        chk("ill halt state", a_state, ST_HALT);
        chk("ill flag", {a_ill, b_ill}, 2'b11);
        chk("ill nop refetch", b_state, ST_FETCH);
        for (int i = 0; i < 20; i++) begin
            step;
            #1;
            chk("halt persists", {a_state, a_req, a_pcw, a_rw, a_irw, a_ill}, {ST_HALT, 5'b00001});
            chk("nop ill sticky", b_ill, 1'b1);
        end
        chk("nop aligned fetch", b_state, ST_FETCH);

        // SW on the non-halting build, then reset mid MEM_WR
        instr = 32'h0020A023;
        step;
        step;
        step;
        rdy = 1'b0;
        #1;
        chk("sw memwr state", b_state, ST_MEM_WR);
        chk("sw memwr ctl", {b_req, b_iord, b_mw}, 3'b111);
        rst = 1'b1;
        #1;
        chk("rst mid wr state", b_state, ST_FETCH);
        chk("rst mid wr quiet", {b_req, b_mw, b_ill}, 3'b000);
        chk("rst clears halt", {a_state, a_ill}, {ST_FETCH, 1'b0});
        step;
        rst = 1'b0;
        rdy = 1'b1;
        #1;
        chk("post rst req", {b_req, b_mw}, 2'b10);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
